// File: rtl/binary_to_stochastic_pkg.sv
// Shared definitions for the stochastic-computing datapath.
//   sc_state_t  : generator FSM states
//   stream_len  : bits per stream for a given binary width
//   lfsr_taps   : maximal-length Fibonacci tap masks (shift-left form), widths 4..8
package sc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GEN  = 2'd1,
        DONE = 2'd2
    } sc_state_t;

    function automatic int unsigned stream_len(input int unsigned length);
        return 32'd1 << length;
    endfunction

    function automatic logic [7:0] lfsr_taps(input int unsigned length);
        case (length)
            4:       return 8'h09;
            5:       return 8'h12;
            6:       return 8'h21;
            7:       return 8'h41;
            8:       return 8'hB8;
            default: return 8'h09;
        endcase
    endfunction

endpackage

// File: rtl/binary_to_stochastic_lfsr.sv
// De Bruijn-extended Fibonacci LFSR. The extra XOR on an all-zero low field
// splices the zero state into the maximal-length cycle, so the period is
// exactly 2^LENGTH and every value appears once per period.
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset, loads SEED
//   en    : advance one step this cycle
//   state : current register value
module sc_lfsr
    import sc_pkg::*;
#(
    parameter int unsigned           LENGTH = 4,
    parameter logic [LENGTH-1:0]     SEED   = 'h9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic [LENGTH-1:0] state
);

    localparam logic [LENGTH-1:0] TAPS = LENGTH'(lfsr_taps(LENGTH));

    logic fb;

    always_comb begin
        fb = (^(state & TAPS)) ^ (state[LENGTH-2:0] == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SEED;
        end else if (en) begin
            state <= {state[LENGTH-2:0], fb};
        end
    end

endmodule

// File: rtl/binary_to_stochastic.sv
// Binary-to-stochastic generator: converts a LENGTH-bit unsigned value into a
// STREAM_LEN-bit unipolar stream holding exactly Bnum ones.
//   clk, rst      : clock, synchronous active-high reset
//   in_valid/ready: input handshake for Bnum
//   Bnum          : value to convert
//   sc_bit        : serial stream bit, qualified by sc_bit_valid
//   SCnum         : parallel stream, bit k == k-th serial bit
//   done          : one-cycle pulse once SCnum is complete
module binary_to_stochastic
    import sc_pkg::*;
#(
    parameter int unsigned           LENGTH     = 4,
    parameter int unsigned           STREAM_LEN = stream_len(LENGTH), // derived; do not override
    parameter logic [LENGTH-1:0]     SEED       = 'h9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LENGTH-1:0]     Bnum,
    output logic                  sc_bit,
    output logic                  sc_bit_valid,
    output logic [STREAM_LEN-1:0] SCnum,
    output logic                  done
);

    sc_state_t         state_q, state_d;
    logic [LENGTH-1:0] val_q;
    logic [LENGTH-1:0] cmpt;
    logic [LENGTH-1:0] cmpt_next;
    logic [LENGTH-1:0] lfsr;
    logic [LENGTH-1:0] cmp_val;
    logic              accept;
    logic              last;
    logic              emit;
    logic              bit_d;

    sc_lfsr #(
        .LENGTH (LENGTH),
        .SEED   (SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .en    (accept || emit),
        .state (lfsr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        in_ready     = 1'b0;
        sc_bit_valid = 1'b0;
        done         = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = GEN;
            end
            GEN: begin
                sc_bit_valid = 1'b1;
                if (last) state_d = DONE;
            end
            DONE: begin
                in_ready = 1'b1;
                done     = 1'b1;
                state_d  = in_valid ? GEN : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // cmpt indexes the bit currently on sc_bit. Bit 0 is produced on the
    // accept edge itself (comparing against Bnum directly, since val_q is
    // only being loaded), so GEN emits bits 1..STREAM_LEN-1 and the LFSR
    // still steps exactly STREAM_LEN times per stream.
    always_comb begin
        accept    = in_valid && in_ready;
        last      = (cmpt == '1);
        emit      = (state_q == GEN) && !last;
        cmpt_next = cmpt + LENGTH'(1);
        cmp_val   = accept ? Bnum : val_q;
        bit_d     = (lfsr < cmp_val);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            val_q  <= '0;
            cmpt   <= '0;
            SCnum  <= '0;
            sc_bit <= 1'b0;
        end else if (accept) begin
            val_q  <= Bnum;
            cmpt   <= '0;
            SCnum  <= {{(STREAM_LEN-1){1'b0}}, bit_d};
            sc_bit <= bit_d;
        end else if (emit) begin
            cmpt            <= cmpt_next;
            SCnum[cmpt_next] <= bit_d;
            sc_bit          <= bit_d;
        end
    end

endmodule

// File: tb/tb_binary_to_stochastic.sv
module tb_binary_to_stochastic;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  Bnum;
    logic        sc_bit;
    logic        sc_bit_valid;
    logic [15:0] SCnum;
    logic        done;
    logic        en_sa;
    logic [3:0]  sa_state;

    int checks   = 0;
    int failures = 0;

    // LFSR sequence from seed 9, worked out by hand for taps 'h9 plus the
    // de Bruijn splice (8 -> 0 -> 1).
    logic [3:0] seq [16] = '{4'd9, 4'd2, 4'd4, 4'd8, 4'd0, 4'd1, 4'd3, 4'd7,
                             4'd15, 4'd14, 4'd13, 4'd10, 4'd5, 4'd11, 4'd6, 4'd12};

    binary_to_stochastic #(
        .LENGTH (4),
        .SEED   (4'h9)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .Bnum         (Bnum),
        .sc_bit       (sc_bit),
        .sc_bit_valid (sc_bit_valid),
        .SCnum        (SCnum),
        .done         (done)
    );

    sc_lfsr #(
        .LENGTH (4),
        .SEED   (4'h9)
    ) u_sa (
        .clk   (clk),
        .rst   (rst),
        .en    (en_sa),
        .state (sa_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_sc(input int v);
        logic [15:0] r;
        r = '0;
        for (int k = 0; k < 16; k++)
            if (32'(seq[k]) < v) r[k] = 1'b1;
        return r;
    endfunction

    // Accept v from IDLE, collect 16 serial bits, end in the DONE cycle.
    task automatic collect(input logic [3:0] v, output logic [15:0] ser);
        chk("ready_before_accept", 32'(in_ready), 1);
        in_valid = 1'b1;
        Bnum     = v;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 16; k++) begin
            chk("gen_valid", 32'(sc_bit_valid), 1);
            chk("gen_not_ready", 32'(in_ready), 0);
            chk("gen_no_done", 32'(done), 0);
            ser[k] = sc_bit;
            tick();
        end
        chk("done_pulse", 32'(done), 1);
        chk("done_valid_low", 32'(sc_bit_valid), 0);
    endtask

    initial begin : stim
        logic [15:0] ser;
        logic [15:0] seen;
        int          done_seen;

        rst      = 1'b1;
        in_valid = 1'b1;
        Bnum     = 4'd5;
        en_sa    = 1'b0;
        tick();
        tick();
        chk("rst_SCnum", 32'(SCnum), 0);
        chk("rst_sc_bit", 32'(sc_bit), 0);
        chk("rst_valid", 32'(sc_bit_valid), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_lfsr", 32'(dut.lfsr), 32'h9);

        rst      = 1'b0;
        in_valid = 1'b0;
        tick();
        chk("post_rst_ready", 32'(in_ready), 1);
        chk("post_rst_idle", 32'(sc_bit_valid), 0);

        // Standalone LFSR: full period, every value once, back to seed.
        en_sa = 1'b1;
        seen  = '0;
        for (int k = 0; k < 16; k++) begin
            chk("lfsr_seq", 32'(sa_state), 32'(seq[k]));
            seen[sa_state] = 1'b1;
            tick();
        end
        chk("lfsr_wrap", 32'(sa_state), 32'h9);
        chk("lfsr_cover", 32'(seen), 32'hFFFF);
        en_sa = 1'b0;

        // Bnum = 0: all-zero stream.
        collect(4'd0, ser);
        chk("b0_SCnum", 32'(SCnum), 0);
        tick();
        chk("b0_done_one_cycle", 32'(done), 0);

        // Bnum = 15: single zero where lfsr == 15 (position 8).
        collect(4'd15, ser);
        chk("b15_SCnum", 32'(SCnum), 32'hFEFF);
        chk("b15_popcount", $countones(SCnum), 15);
        chk("b15_serial", 32'(ser), 32'(SCnum));
        tick();
        chk("b15_done_one_cycle", 32'(done), 0);

        // Full sweep, in_valid held high, 17-cycle spacing.
        in_valid = 1'b1;
        Bnum     = 4'd0;
        for (int v = 0; v < 16; v++) begin
            tick();
            for (int k = 0; k < 16; k++) begin
                chk("sweep_valid", 32'(sc_bit_valid), 1);
                chk("sweep_not_ready", 32'(in_ready), 0);
                ser[k] = sc_bit;
                if (k < 15) tick();
            end
            Bnum = 4'(v + 1);
            if (v == 15) in_valid = 1'b0;
            tick();
            chk("sweep_done", 32'(done), 1);
            chk("sweep_ready_done", 32'(in_ready), 1);
            chk("sweep_SCnum", 32'(SCnum), 32'(exp_sc(v)));
            chk("sweep_popcount", $countones(SCnum), v);
            chk("sweep_serial", 32'(ser), 32'(SCnum));
        end
        tick();
        chk("sweep_idle_done", 32'(done), 0);
        chk("sweep_idle_ready", 32'(in_ready), 1);

        // Bnum = 6 with in_valid/Bnum disturbances during GEN.
        in_valid = 1'b1;
        Bnum     = 4'd6;
        tick();
        in_valid = 1'b0;
        Bnum     = 4'd3;
        for (int k = 0; k < 16; k++) begin
            chk("ign_valid", 32'(sc_bit_valid), 1);
            ser[k] = sc_bit;
            if (k == 3) begin in_valid = 1'b1; Bnum = 4'd15; end
            if (k == 4) in_valid = 1'b0;
            if (k < 15) tick();
        end
        tick();
        chk("b6_done", 32'(done), 1);
        chk("b6_SCnum", 32'(SCnum), 32'h1076);
        chk("b6_serial", 32'(ser), 32'(SCnum));
        chk("b6_reconv", $countones(SCnum), 6);

        // Handshake in DONE starts Bnum = 10; reset hits at T+5.
        in_valid = 1'b1;
        Bnum     = 4'd10;
        tick();
        in_valid = 1'b0;
        chk("b2b_valid", 32'(sc_bit_valid), 1);
        chk("b2b_bit0", 32'(sc_bit), 1);
        tick();
        tick();
        tick();
        tick();
        chk("pre_rst_SCnum", 32'(SCnum), 32'h001F);
        rst = 1'b1;
        tick();
        chk("midrst_SCnum", 32'(SCnum), 0);
        chk("midrst_valid", 32'(sc_bit_valid), 0);
        chk("midrst_done", 32'(done), 0);
        chk("midrst_lfsr", 32'(dut.lfsr), 32'h9);
        rst       = 1'b0;
        done_seen = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (done) done_seen++;
        end
        chk("midrst_no_done", done_seen, 0);

        collect(4'd10, ser);
        chk("b10_SCnum", 32'(SCnum), 32'h50FF);
        chk("b10_popcount", $countones(SCnum), 10);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
